div: RTL and testbench

Iterative 32-bit radix-2 restoring divider serving the EX stage for DIV/DIVU.
- EX asserts start with operands and holds the pipeline stalled until this block raises ready.
- The block returns {remainder, quotient} for EX to write into HI/LO.
- Signed and unsigned division share one datapath: signed operands are converted to magnitudes, and the result signs are fixed at the end.

---
 rtl/div_pkg.sv | 38 +++
 rtl/div_step.sv | 23 ++
 rtl/div.sv | 129 ++++++++++++
 tb/tb_div.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared divider definitions: state encodings, handshake levels, bus widths.
// The DIV_ZERO_DETECT_EN macro (consumed in div.sv) enables the divide-by-zero short path.
package div_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned WorkBus      = DoubleRegBus + 1;
  localparam int unsigned CntBus       = 6;

  localparam logic [RegBus-1:0]       ZeroWord       = '0;
  localparam logic [DoubleRegBus-1:0] ZeroDoubleWord = '0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Operation context captured at start, used for the final sign fix
  typedef struct packed {
    logic signed_div;
    logic sign1;
    logic sign2;
  } div_sign_t;

  // Two's-complement negation when neg is set, pass-through otherwise
  function automatic logic [RegBus-1:0] magnitude(input logic [RegBus-1:0] x,
                                                  input logic              neg);
    return neg ? RegBus'((~x) + RegBus'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// partial-remainder window, then restore-and-shift or commit-and-shift.
module div_step
  import div_pkg::*;
(
  input  logic [DoubleRegBus-1:0] dividend,
  input  logic [RegBus-1:0]       divisor,
  output logic [WorkBus-1:0]      next_dividend_c
);

  logic [RegBus:0] minuend;

  assign minuend = {1'b0, dividend[DoubleRegBus-1:RegBus]} - {1'b0, divisor};

  // A borrow means the divisor did not fit: keep the window and shift in a 0
  always_comb begin
    next_dividend_c = {dividend, 1'b0};
    if (!minuend[RegBus]) begin
      next_dividend_c = {minuend[RegBus-1:0], dividend[RegBus-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU; returns {rem, quo}.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to a zero result.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

`ifdef DIV_ZERO_DETECT_EN
  localparam logic ZeroDetect = 1'b1;
`else
  localparam logic ZeroDetect = 1'b0;
`endif

  div_state_e              state_q, state_d;
  logic [CntBus-1:0]       cnt_q, cnt_d;
  logic [WorkBus-1:0]      dividend_q, dividend_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  div_sign_t               sign_q, sign_d;
  logic [DoubleRegBus-1:0] result_d;
  logic                    ready_d;

  logic [WorkBus-1:0]      step_c;
  logic [RegBus-1:0]       quo_fix, rem_fix;
  logic                    zero_divisor;

  div_step u_step (
    .dividend        (dividend_q[DoubleRegBus-1:0]),
    .divisor         (divisor_q),
    .next_dividend_c (step_c)
  );

  // Quotient sits in the low word, remainder in the bits above the spare LSB
  assign quo_fix = magnitude(dividend_q[RegBus-1:0],
                             sign_q.signed_div & (sign_q.sign1 ^ sign_q.sign2));
  assign rem_fix = magnitude(dividend_q[WorkBus-1:RegBus+1],
                             sign_q.signed_div & sign_q.sign1);

  assign zero_divisor = ZeroDetect && (opdata2_i == ZeroWord);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign_q     <= '0;
      result_o   <= ZeroDoubleWord;
      ready_o    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign_q     <= sign_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign_d     = sign_q;
    result_d   = result_o;
    ready_d    = ready_o;

    case (state_q)
      DivFree: begin
        // A start coinciding with a flush is dropped
        if (start_i == DivStart && !annul_i) begin
          divisor_d         = magnitude(opdata2_i, signed_div_i & opdata2_i[RegBus-1]);
          dividend_d        = {ZeroWord,
                               magnitude(opdata1_i, signed_div_i & opdata1_i[RegBus-1]),
                               1'b0};
          sign_d.signed_div = signed_div_i;
          sign_d.sign1      = opdata1_i[RegBus-1];
          sign_d.sign2      = opdata2_i[RegBus-1];
          cnt_d             = '0;
          state_d           = zero_divisor ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        result_d = ZeroDoubleWord;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = ZeroDoubleWord;
          cnt_d    = '0;
        end else if (cnt_q != CntBus'(RegBus)) begin
          dividend_d = step_c;
          cnt_d      = cnt_q + CntBus'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        // Result is held until EX releases start
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = ZeroDoubleWord;
        end
      end

      default: state_d = DivFree;
    endcase
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block (both zero-detect builds).
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start with operands, count cycles until ready (bounded), optionally drop start
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic keep, output logic [63:0] res, output int lat);
    @(negedge clk);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    lat        = 0;
    do begin
      @(negedge clk);
      lat++;
      opdata1 = $urandom;
      opdata2 = $urandom;
    end while (ready_o !== 1'b1 && lat < 100);
    res = result_o;
    if (!keep) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #12;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++;
    if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [63:0] res;
    int lat;
    run_div(32'd100, 32'd7, 1'b0, 1'b0, res, lat);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL u100_7_latency: got %0d expected 34", lat); end
    checks++;
    if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL u100_7_result: got %h expected %h", res, {32'd2, 32'd14}); end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL u100_7_release: got ready %b result %h expected 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int lat;
    run_div(32'hFFFFFFF9, 32'h2, 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      errors++; $display("FAIL s_m7_2: got %h expected %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    end
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== {32'h1, 32'hFFFFFFFD}) begin
      errors++; $display("FAIL s_7_m2: got %h expected %h", res, {32'h1, 32'hFFFFFFFD});
    end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL s_7_m2_latency: got %0d expected 34", lat); end
    // Same bit pattern as unsigned gives a different answer
    run_div(32'hFFFFFFF9, 32'h2, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {32'h1, 32'h7FFFFFFC}) begin
      errors++; $display("FAIL u_fff9_2: got %h expected %h", res, {32'h1, 32'h7FFFFFFC});
    end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res;
    int lat;
    run_div(32'h1234, 32'h0, 1'b0, 1'b0, res, lat);
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    checks++;
    if (res !== 64'h0) begin errors++; $display("FAIL dz_result: got %h expected 0", res); end
`else
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL dz_latency: got %0d expected 34", lat); end
    checks++;
    if (res !== {32'h00001234, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL dz_result: got %h expected %h", res, {32'h00001234, 32'hFFFFFFFF});
    end
`endif
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL annul_flush: got ready %b result %h expected 0/0", ready_o, result_o);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL annul_stays_idle: got ready %b expected 0", ready_o); end
    run_div(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {32'd0, 32'd3} || lat !== 34) begin
      errors++; $display("FAIL annul_next_div: got %h lat %0d expected %h lat 34", res, lat, {32'd0, 32'd3});
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL rst_midop: got ready %b result %h expected 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b1;
    // Reset landing between edges while a result is held must clear it at once
    run_div(32'd100, 32'd7, 1'b0, 1'b1, res, lat);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL rst_in_end: got ready %b result %h expected 0/0", ready_o, result_o);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, res, lat);
    checks++;
    if (res !== {32'h0, 32'h80000000} || lat !== 34) begin
      errors++; $display("FAIL overflow: got %h lat %0d expected %h lat 34", res, lat, {32'h0, 32'h80000000});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    run_div(32'd50, 32'd5, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {32'd0, 32'd10} || lat !== 34) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 34", res, lat, {32'd0, 32'd10});
    end
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {32'hF, 32'h0FFFFFFF} || lat !== 34) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 34", res, lat, {32'hF, 32'h0FFFFFFF});
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
